// File: rtl/sr_drive_encoder.sv
// sr_drive_encoder: turns target Q vectors into s/r pulses for an SR flop bank,
// tracking the expected bank state and checking the fed-back Q.
module sr_drive_encoder #(
  parameter int WIDTH        = 8,
  parameter int PULSE_CYCLES = 1,
  parameter int GAP_CYCLES   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] tgt_mask,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  input  logic [WIDTH-1:0] fb_q,
  output logic [WIDTH-1:0] shadow_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_bits,
  input  logic             err_clr
);

  localparam int MAXC =
    (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] set_q;
  logic [WIDTH-1:0] clr_q;
  logic [WIDTH-1:0] set_n;
  logic [WIDTH-1:0] clr_n;
  logic [WIDTH-1:0] diff;
  logic             accept;
  logic             cmp;

  assign tgt_ready = (state == IDLE) & ~rst;
  assign busy      = (state != IDLE);
  assign accept    = tgt_valid & tgt_ready;

  // set and clr are disjoint by construction: data selects one or the other
  assign set_n = tgt_mask & tgt_data & ~shadow_q;
  assign clr_n = tgt_mask & ~tgt_data & shadow_q;

  assign diff = fb_q ^ shadow_q;
  assign cmp  = (state == GAP) && (cnt == G_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      s_out    <= '0;
      r_out    <= '0;
      shadow_q <= '0;
      set_q    <= '0;
      clr_q    <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            set_q <= set_n;
            clr_q <= clr_n;
            if ((set_n | clr_n) == '0) begin
              done <= 1'b1;
            end else begin
              state <= DRIVE;
              s_out <= set_n;
              r_out <= clr_n;
              cnt   <= '0;
            end
          end
        end
        DRIVE: begin
          if (cnt == P_LAST) begin
            s_out    <= '0;
            r_out    <= '0;
            shadow_q <= (shadow_q | set_q) & ~clr_q;
            cnt      <= '0;
            state    <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cmp) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          s_out <= '0;
          r_out <= '0;
        end
      endcase
    end
  end

  // a mismatch on the clearing edge replaces the old history
  always_ff @(posedge clk) begin
    if (rst) begin
      err      <= 1'b0;
      err_bits <= '0;
    end else if (cmp && (diff != '0)) begin
      err      <= 1'b1;
      err_bits <= err_clr ? diff : (err_bits | diff);
    end else if (err_clr) begin
      err      <= 1'b0;
      err_bits <= '0;
    end
  end

endmodule

// File: tb/tb_sr_drive_encoder.sv
// tb_sr_drive_encoder: two encoder instances (1/1 and 3/2 timing) against a
// command-timeline reference model, plus directed literal checks.
module tb_sr_drive_encoder;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   rst, valid, errclr;
  logic [1:0]   ready, busy, done, err;
  logic [W-1:0] data[2], mask[2], fb[2];
  logic [W-1:0] s[2], r[2], sh[2], eb[2];
  logic [W-1:0] glitch[2], stuckv[2];
  bit           stuck[2];

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  sr_drive_encoder #(.WIDTH(W), .PULSE_CYCLES(1), .GAP_CYCLES(1)) u0 (
    .clk(clk), .rst(rst[0]), .tgt_valid(valid[0]), .tgt_data(data[0]),
    .tgt_mask(mask[0]), .tgt_ready(ready[0]), .s_out(s[0]), .r_out(r[0]),
    .fb_q(fb[0]), .shadow_q(sh[0]), .busy(busy[0]), .done(done[0]),
    .err(err[0]), .err_bits(eb[0]), .err_clr(errclr[0])
  );

  sr_drive_encoder #(.WIDTH(W), .PULSE_CYCLES(3), .GAP_CYCLES(2)) u1 (
    .clk(clk), .rst(rst[1]), .tgt_valid(valid[1]), .tgt_data(data[1]),
    .tgt_mask(mask[1]), .tgt_ready(ready[1]), .s_out(s[1]), .r_out(r[1]),
    .fb_q(fb[1]), .shadow_q(sh[1]), .busy(busy[1]), .done(done[1]),
    .err(err[1]), .err_bits(eb[1]), .err_clr(errclr[1])
  );

  function automatic int pc(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int gc(int i);
    return (i == 0) ? 1 : 2;
  endfunction

  task automatic chk(string name, int i, logic [W-1:0] got,
                     logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s[u%0d] got %b expected %b at %0t",
               name, i, got, exp, $time);
    end
  endtask

  // flop bank: set/reset behaviour, optional stuck value or bit glitches
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) fb[i] <= '0;
      else if (stuck[i]) fb[i] <= stuckv[i];
      else fb[i] <= ((fb[i] | s[i]) & ~r[i]) ^ glitch[i];
    end
  end

  // reference: k = cycles since the accepting edge of a pulsing command
  int           k[2];
  logic [W-1:0] mset[2], mclr[2], msh[2], merrb[2], mdiff;
  bit           merr[2], mdone[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        k[i] = 0; msh[i] = '0; merr[i] = 0; merrb[i] = '0;
        mdone[i] = 0; mset[i] = '0; mclr[i] = '0;
      end else begin
        mdone[i] = 0;
        if (k[i] == 0) begin
          if (errclr[i]) begin merr[i] = 0; merrb[i] = '0; end
          if (valid[i]) begin
            mset[i] = mask[i] & data[i] & ~msh[i];
            mclr[i] = mask[i] & ~data[i] & msh[i];
            if ((mset[i] | mclr[i]) == '0) mdone[i] = 1;
            else k[i] = 1;
          end
        end else if (k[i] == pc(i) + gc(i)) begin
          mdiff = fb[i] ^ msh[i];
          if (mdiff != '0) begin
            merr[i] = 1;
            merrb[i] = errclr[i] ? mdiff : (merrb[i] | mdiff);
          end else if (errclr[i]) begin
            merr[i] = 0; merrb[i] = '0;
          end
          mdone[i] = 1;
          k[i] = 0;
        end else begin
          if (errclr[i]) begin merr[i] = 0; merrb[i] = '0; end
          if (k[i] == pc(i)) msh[i] = (msh[i] | mset[i]) & ~mclr[i];
          k[i]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic on;
        on = (k[i] >= 1) && (k[i] <= pc(i));
        chk("s_out", i, s[i], on ? mset[i] : '0);
        chk("r_out", i, r[i], on ? mclr[i] : '0);
        chk("s_and_r", i, s[i] & r[i], '0);
        chk("shadow_q", i, sh[i], msh[i]);
        chk("busy", i, W'(busy[i]), W'(k[i] != 0));
        chk("done", i, W'(done[i]), W'(mdone[i]));
        chk("ready", i, W'(ready[i]), W'((k[i] == 0) && !rst[i]));
        chk("err", i, W'(err[i]), W'(merr[i]));
        chk("err_bits", i, eb[i], merrb[i]);
      end
    end
  end

  // leaves the caller at the negedge one cycle after the accepting edge
  task automatic cmd(int i, logic [W-1:0] d, logic [W-1:0] m);
    int n;
    data[i] = d; mask[i] = m; valid[i] = 1'b1;
    n = 0;
    while (!ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL accept_timeout[u%0d] got ready=0 expected ready=1", i);
    end
    @(negedge clk);
    valid[i] = 1'b0;
  endtask

  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 2'b11; valid = '0; errclr = '0;
    for (int i = 0; i < 2; i++) begin
      data[i] = '0; mask[i] = '0; glitch[i] = '0;
      stuck[i] = 0; stuckv[i] = '0;
    end

    @(negedge clk);
    chk("rst_ready", 0, W'(ready[0]), '0);
    chk("rst_s", 0, s[0], 4'b0000);
    @(negedge clk);
    chk("rst_ready2", 0, W'(ready[0]), '0);
    chk("rst_shadow", 0, sh[0], 4'b0000);
    chk("rst_err", 0, W'(err[0]), '0);
    chk_en = 1;
    rst = 2'b00;
    @(negedge clk);
    chk("post_rst_ready", 0, W'(ready[0]), W'(1'b1));

    cmd(0, 4'b1010, 4'b1111);
    chk("lit_s1", 0, s[0], 4'b1010);
    chk("lit_r1", 0, r[0], 4'b0000);
    wait_n(1);
    chk("lit_s1_end", 0, s[0], 4'b0000);
    chk("lit_sh1", 0, sh[0], 4'b1010);
    wait_n(1);
    chk("lit_done1", 0, W'(done[0]), W'(1'b1));
    chk("lit_err1", 0, W'(err[0]), '0);

    cmd(0, 4'b0110, 4'b1111);
    chk("lit_s2", 0, s[0], 4'b0100);
    chk("lit_r2", 0, r[0], 4'b1000);
    wait_n(2);
    chk("lit_sh2", 0, sh[0], 4'b0110);

    cmd(0, 4'b1111, 4'b0000);
    chk("lit_nop_done", 0, W'(done[0]), W'(1'b1));
    chk("lit_nop_busy", 0, W'(busy[0]), '0);
    chk("lit_nop_sh", 0, sh[0], 4'b0110);

    cmd(0, 4'b0000, 4'b1111);
    wait_n(2);
    stuck[0] = 1; stuckv[0] = 4'b0000;
    cmd(0, 4'b0110, 4'b1111);
    wait_n(2);
    chk("lit_err_stuck", 0, W'(err[0]), W'(1'b1));
    chk("lit_eb_stuck", 0, eb[0], 4'b0110);

    cmd(0, 4'b1001, 4'b1111);
    wait_n(1);
    errclr[0] = 1'b1;
    wait_n(1);
    errclr[0] = 1'b0;
    chk("lit_err_race", 0, W'(err[0]), W'(1'b1));
    chk("lit_eb_race", 0, eb[0], 4'b1001);
    errclr[0] = 1'b1;
    wait_n(1);
    errclr[0] = 1'b0;
    chk("lit_err_clr", 0, W'(err[0]), '0);
    chk("lit_eb_clr", 0, eb[0], 4'b0000);
    stuck[0] = 0;

    cmd(1, 4'b0101, 4'b1111);
    chk("lit_p3_a", 1, s[1], 4'b0101);
    wait_n(1);
    chk("lit_p3_b", 1, s[1], 4'b0101);
    wait_n(1);
    chk("lit_p3_c", 1, s[1], 4'b0101);
    wait_n(1);
    chk("lit_p3_end", 1, s[1], 4'b0000);
    data[1] = 4'b1100; mask[1] = 4'b1111; valid[1] = 1'b1;
    wait_n(1);
    chk("lit_hold_ready", 1, W'(ready[1]), '0);
    chk("lit_hold_busy", 1, W'(busy[1]), W'(1'b1));
    wait_n(1);
    chk("lit_lat_ready", 1, W'(ready[1]), W'(1'b1));
    chk("lit_lat_done", 1, W'(done[1]), W'(1'b1));
    wait_n(1);
    valid[1] = 1'b0;
    chk("lit_s_next", 1, s[1], 4'b1000);
    chk("lit_r_next", 1, r[1], 4'b0001);
    rst[1] = 1'b1;
    wait_n(1);
    chk("lit_abort_s", 1, s[1], 4'b0000);
    chk("lit_abort_r", 1, r[1], 4'b0000);
    chk("lit_abort_sh", 1, sh[1], 4'b0000);
    chk("lit_abort_busy", 1, W'(busy[1]), '0);
    rst[1] = 1'b0;
    wait_n(1);
    chk("lit_abort_done", 1, W'(done[1]), '0);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        logic [W-1:0] g;
        g = W'(1) << $urandom_range(0, W - 1);
        valid[i]  = $urandom_range(0, 1) == 1;
        data[i]   = W'($urandom);
        mask[i]   = W'($urandom);
        errclr[i] = $urandom_range(0, 15) == 0;
        glitch[i] = ($urandom_range(0, 7) == 0) ? g : '0;
        rst[i]    = $urandom_range(0, 149) == 0;
      end
    end

    @(negedge clk);
    valid = '0; errclr = '0; rst = '0;
    glitch[0] = '0; glitch[1] = '0;
    wait_n(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
